// File: rtl/window_frame_ctrl_pkg.sv
// Shared types and constants for the window frame controller.
package window_frame_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_IMG_W = 100;
    localparam int DEF_IMG_H = 100;

    // Bits needed to count 0..v-1, never less than one.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/window_frame_ctrl_pos_counter.sv
// Row/column position of the incoming pixel stream, with frame-end and
// interior (full 3x3 window available) flags for the current position.
module win_pos_counter
    import window_frame_ctrl_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int ROW_W = clog2(IMG_H),
    parameter int COL_W = clog2(IMG_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             adv_i,
    output logic [ROW_W-1:0] row_o,
    output logic [COL_W-1:0] col_o,
    output logic             last_o,
    output logic             qual_o
);

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             row_last, col_last;

    assign row_last = (row_q == ROW_W'(IMG_H - 1));
    assign col_last = (col_q == COL_W'(IMG_W - 1));

    // Next position: clear wins, otherwise step one pixel in raster order.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
        end else if (adv_i) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = row_last & col_last;
    // The window is fully inside the image once two rows and two columns
    // have been seen, so border results are never forwarded.
    assign qual_o = (row_q >= ROW_W'(2)) & (col_q >= COL_W'(2));

endmodule

// File: rtl/window_frame_ctrl.sv
// Frame sequencer between UART RX/TX and the 3x3 window datapath: accepts
// pixels, shifts the window, forwards interior results one byte at a time.
module window_frame_ctrl
    import window_frame_ctrl_pkg::*;
#(
    parameter int IMG_W   = DEF_IMG_W,
    parameter int IMG_H   = DEF_IMG_H,
    parameter int WIN_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      win_clr,
    output logic                      win_en,
    input  logic [7:0]                win_pix,
    output logic [7:0]                tx_data,
    output logic                      tx_start,
    input  logic                      tx_busy,
    output logic [clog2(IMG_H)-1:0]   row,
    output logic [clog2(IMG_W)-1:0]   col,
    output logic                      frame_done,
    output logic                      busy
);

    if (IMG_W < 3 || IMG_H < 3 || WIN_LAT < 1 || WIN_LAT > 4) begin : g_bad_cfg
        $error("window_frame_ctrl: IMG_W/IMG_H must be >= 3 and WIN_LAT in 1..4");
    end

    state_t             state_q;
    logic [7:0]         tx_data_q;
    logic               out_pend_q;
    logic               tx_guard_q;
    logic [WIN_LAT-1:0] vld_pipe_q;

    logic accept, qacc, pos_last, pos_qual, pipe_busy, arrive;

    assign pipe_busy  = |vld_pipe_q;
    assign arrive     = vld_pipe_q[WIN_LAT-1];

    // Only one result may be in flight, so input stalls until it is sent.
    assign in_ready   = (state_q == ST_RUN) & ~out_pend_q & ~pipe_busy;
    assign accept     = in_valid & in_ready;
    assign win_en     = accept;
    assign win_clr    = (state_q == ST_IDLE) & start & ~rst;
    assign qacc       = accept & pos_qual;
    // The guard hides the one cycle before the UART reports busy.
    assign tx_start   = out_pend_q & ~tx_busy & ~tx_guard_q;
    assign tx_data    = tx_data_q;
    assign frame_done = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);

    win_pos_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_pos (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (win_clr),
        .adv_i  (accept),
        .row_o  (row),
        .col_o  (col),
        .last_o (pos_last),
        .qual_o (pos_qual)
    );

    // Frame state machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (start) state_q <= ST_RUN;
                ST_RUN:   if (accept && pos_last) state_q <= ST_DRAIN;
                ST_DRAIN: if (!pipe_busy && !out_pend_q) state_q <= ST_DONE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    // Qualified-accept flags follow the datapath latency to win_pix.
    if (WIN_LAT == 1) begin : g_pipe1
        always_ff @(posedge clk) begin
            if (rst) vld_pipe_q <= '0;
            else     vld_pipe_q <= qacc;
        end
    end else begin : g_pipeN
        always_ff @(posedge clk) begin
            if (rst) vld_pipe_q <= '0;
            else     vld_pipe_q <= {vld_pipe_q[WIN_LAT-2:0], qacc};
        end
    end

    // Capture arriving result and hand it to the UART transmitter.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data_q  <= '0;
            out_pend_q <= 1'b0;
            tx_guard_q <= 1'b0;
        end else begin
            tx_guard_q <= tx_start;
            if (arrive) begin
                tx_data_q  <= win_pix;
                out_pend_q <= 1'b1;
            end else if (tx_start) begin
                out_pend_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_window_frame_ctrl.sv
// Bench for window_frame_ctrl on a 5x4 frame: scenario table plus
// hand-written corner sequences, checked against a raster-order model.
module tb_window_frame_ctrl;

    localparam int W     = 5;
    localparam int H     = 4;
    localparam int TOTAL = W * H;
    localparam int NOUT  = (W - 2) * (H - 2);

    logic       clk = 1'b0;
    logic       rst, start, in_valid, tx_busy;
    logic       in_ready, win_clr, win_en, tx_start, frame_done, busy;
    logic [7:0] win_pix = 8'd0;
    logic [7:0] tx_data;
    logic [1:0] row;
    logic [2:0] col;

    window_frame_ctrl #(.IMG_W(W), .IMG_H(H), .WIN_LAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .win_clr(win_clr), .win_en(win_en),
        .win_pix(win_pix), .tx_data(tx_data), .tx_start(tx_start),
        .tx_busy(tx_busy), .row(row), .col(col),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected byte k: interior pixels in raster order, value = accept index.
    function automatic int exp_pix(input int k);
        return (2 + k / (W - 2)) * W + 2 + k % (W - 2);
    endfunction

    // Datapath stand-in: win_pix is the accept index, one cycle after win_en.
    int pix_idx = 0;
    always @(posedge clk) begin
        if (rst || win_clr) begin
            pix_idx <= 0;
            win_pix <= 8'd0;
        end else if (win_en) begin
            win_pix <= 8'(pix_idx);
            pix_idx <= pix_idx + 1;
        end
    end

    // Stimulus knobs and UART busy schedule.
    int pct = 0, bdly = 0, bhold = 0;
    int cyc = 0, rise = 0, fall = 0;

    initial begin
        in_valid = 1'b0;
        tx_busy  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            in_valid = (int'($urandom_range(99)) < pct);
            tx_busy  = (cyc >= rise) && (cyc < fall);
        end
    end

    // Reference model state.
    int acc_n = 0, outst = 0, k_out = 0, n_done = 0, n_clr = 0;
    bit m_busy = 0, prev_txs = 0;

    initial begin
        bit exp_rdy;
        forever begin
            @(negedge clk);
            if (rst) begin
                acc_n = 0; outst = 0; k_out = 0; m_busy = 0; prev_txs = 0;
            end else begin
                exp_rdy = m_busy && (acc_n < TOTAL) && (outst == 0);
                chk("busy", busy, m_busy);
                chk("in_ready", in_ready, exp_rdy);
                chk("win_en", win_en, in_valid & exp_rdy);
                chk("win_clr", win_clr, start & !m_busy);
                if (m_busy) begin
                    chk("row", row, (acc_n % TOTAL) / W);
                    chk("col", col, acc_n % W);
                end
                if (tx_start) begin
                    chk("tx_adjacent", prev_txs, 0);
                    chk("tx_while_busy", tx_busy, 0);
                    chk("tx_spurious", outst > 0, 1);
                    chk("tx_data", tx_data, exp_pix(k_out));
                    k_out++;
                    if (outst > 0) outst--;
                    if (bhold > 0) begin
                        rise = cyc + 1 + bdly;
                        fall = rise + bhold;
                    end
                end
                prev_txs = tx_start;
                if (frame_done) begin
                    n_done++;
                    chk("done_bytes", k_out, NOUT);
                    chk("done_drained", (acc_n == TOTAL) && (outst == 0), 1);
                end
                if (win_en) begin
                    if ((acc_n % TOTAL) / W >= 2 && acc_n % W >= 2) outst++;
                    acc_n++;
                end
                if (start && !m_busy) begin
                    m_busy = 1; acc_n = 0; outst = 0; k_out = 0; n_clr++;
                end else if (frame_done) begin
                    m_busy = 0;
                end
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int d0);
        int cnt = 0;
        while (n_done == d0 && cnt < 3000) begin
            @(posedge clk);
            cnt++;
        end
        chk({name, "_timeout"}, cnt < 3000, 1);
    endtask

    task automatic run_frame(input string name, input int exp_tx, input int exp_done);
        int d0 = n_done;
        int c0 = n_clr;
        pulse_start();
        wait_done(name, d0);
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_frames"}, n_done - d0, exp_done);
        chk({name, "_clears"}, n_clr - c0, 1);
        chk({name, "_bytes"}, k_out, exp_tx);
        chk({name, "_idle"}, busy, 0);
    endtask

    typedef struct {
        string name;
        int    pct;
        int    dly;
        int    hold;
        int    exp_tx;
        int    exp_done;
    } scen_t;

    scen_t tbl[4];

    initial begin
        int cnt;
        int d0;
        tbl[0] = '{"basic",  100, 0, 0,  NOUT, 1};
        tbl[1] = '{"bkpr",   100, 0, 10, NOUT, 1};
        tbl[2] = '{"guard",  100, 1, 3,  NOUT, 1};
        tbl[3] = '{"sparse", 30,  0, 0,  NOUT, 1};

        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_row", row, 0);
        chk("rst_col", col, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_win_en", win_en, 0);

        foreach (tbl[i]) begin
            pct = tbl[i].pct; bdly = tbl[i].dly; bhold = tbl[i].hold;
            run_frame(tbl[i].name, tbl[i].exp_tx, tbl[i].exp_done);
            pct = 0; bhold = 0; rise = 0; fall = 0;
            repeat (2) @(posedge clk);
        end

        // in_valid while idle is not consumed
        pct = 100;
        repeat (6) @(posedge clk);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_row", row, 0);
        chk("idle_col", col, 0);

        // start while running is ignored; frame still completes normally
        d0 = n_done;
        pulse_start();
        cnt = 0;
        while (acc_n < 5 && cnt < 200) begin @(negedge clk); cnt++; end
        chk("run_reach5", acc_n >= 5, 1);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done("restart", d0);
        repeat (3) @(posedge clk);
        #1;
        chk("restart_clears", n_clr, 5);
        chk("restart_bytes", k_out, NOUT);

        // reset mid-frame after 9 accepts: no frame_done, clean restart
        d0 = n_done;
        pulse_start();
        cnt = 0;
        while (acc_n < 9 && cnt < 200) begin @(negedge clk); cnt++; end
        chk("mid_reach9", acc_n, 9);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        rise = 0; fall = 0;
        chk("mid_busy", busy, 0);
        chk("mid_row", row, 0);
        chk("mid_col", col, 0);
        chk("mid_tx_data", tx_data, 0);
        chk("mid_tx_start", tx_start, 0);
        chk("mid_in_ready", in_ready, 0);
        chk("mid_win_en", win_en, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("mid_no_done", n_done - d0, 0);
        run_frame("after_rst", NOUT, 1);

        pct = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
